// File: rtl/serial_subtractor_word.sv
// Word-level bit-serial subtractor: a - b computed LSB-first, one bit per clock,
// with a valid/ready handshake on both the operand and result sides.
module serial_subtractor_word #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_e;

    typedef enum logic {
        NB = 1'b0,
        B  = 1'b1
    } bs_e;

    ctrl_e             ctrl_q, ctrl_d;
    bs_e               bs_q, bs_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              amsb_q, amsb_d;
    logic              bmsb_q, bmsb_d;
    logic              ovf_q, ovf_d;

    logic              x, y, dbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= IDLE;
            bs_q   <= NB;
            sa_q   <= '0;
            sb_q   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            bs_q   <= bs_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        bs_d   = bs_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        ovf_d  = ovf_q;

        x    = sa_q[0];
        y    = sb_q[0];
        dbit = x ^ y ^ (bs_q == B);

        case (ctrl_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d   = a;
                    sb_d   = b;
                    amsb_d = a[WIDTH-1];
                    bmsb_d = b[WIDTH-1];
                    diff_d = '0;
                    bs_d   = NB;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    ctrl_d = RUN;
                end
            end
            RUN: begin
                diff_d = {dbit, diff_q[WIDTH-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                case (bs_q)
                    NB:      bs_d = (~x & y) ? B : NB;
                    B:       bs_d = (x & ~y) ? NB : B;
                    default: bs_d = NB;
                endcase
                // dbit is the result MSB on the final bit, so overflow is latched here
                if (cnt_q == CW'(WIDTH - 1)) begin
                    ovf_d  = (amsb_q != bmsb_q) & (dbit != amsb_q);
                    ctrl_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ctrl_d = IDLE;
                end
            end
            default: ctrl_d = IDLE;
        endcase
    end

    assign in_ready  = (ctrl_q == IDLE);
    assign out_valid = (ctrl_q == DONE);
    assign diff      = diff_q;
    assign borrow    = (bs_q == B);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_word.sv
// Bench for serial_subtractor_word: directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_subtractor_word;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_word #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int sx, sy, sd;
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        d  = W'((int'(x) - int'(y)) & ((1 << W) - 1));
        bo = (int'(x) < int'(y));
        ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    endfunction

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic finish_op(input string nm, input logic [W-1:0] ed, input logic eb,
                             input logic eo, input int stall, input int lat0, input bit chklat);
        int lat;
        lat = lat0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " valid"}, {31'd0, out_valid}, 32'd1);
        if (chklat) chk({nm, " latency"}, lat, W);
        chk({nm, " diff"}, {24'd0, diff}, {24'd0, ed});
        chk({nm, " borrow"}, {31'd0, borrow}, {31'd0, eb});
        chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({nm, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, " hold res"}, {22'd0, diff, borrow, ovf}, {22'd0, ed, eb, eo});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({nm, " idle out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " idle keep"}, {22'd0, diff, borrow, ovf}, {22'd0, ed, eb, eo});
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] md;
        logic         mb, mo;
        int           seen;

        vecs[0] = '{8'd200, 8'd55,  8'h91, 1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  8'hFB, 1'b1, 1'b0};
        vecs[2] = '{8'h80,  8'h01,  8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00,  8'h00,  8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF,  8'hFF,  8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'h80,  8'h80, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset outputs", {22'd0, diff, borrow, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, back-to-back
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov, 0, 0, 1'b1);
        end

        // in_valid toggling during RUN is ignored
        start_op(8'h3C, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom);
            b = W'($urandom);
            chk("toggle in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        model(8'h3C, 8'h5A, md, mb, mo);
        finish_op("toggle", md, mb, mo, 0, 6, 1'b0);

        // Result held through a 5-cycle consumer stall
        model(8'hA5, 8'h3C, md, mb, mo);
        start_op(8'hA5, 8'h3C);
        finish_op("stall5", md, mb, mo, 5, 0, 1'b1);

        // Reset while bit 3 is in flight
        start_op(8'hC3, 8'h5E);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort outputs", {22'd0, diff, borrow, ovf}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no valid", seen, 0);
        start_op(8'd3, 8'd1);
        finish_op("after abort", 8'h02, 1'b0, 1'b0, 0, 0, 1'b1);

        // Randomized operations with input gaps and output stalls
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ((i % 50) == 0) rb = ra;
            model(ra, rb, md, mb, mo);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_op(ra, rb);
            finish_op("rand", md, mb, mo, $urandom_range(0, 3), 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
